// File: rtl/multicycle_control_if.sv
// Control/datapath bundle between the multicycle MIPS controller and its datapath.
// master = controller (consumes instruction fields and flags, drives control lines).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_control, alu_src_a, alu_src_b, pc_src, pc_write, ir_write,
           mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_control, alu_src_a, alu_src_b, pc_src, pc_write, ir_write,
           mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: Moore sequencer with memory wait handling,
// retired-instruction counter and sticky illegal/bus-error flags.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction, PC+4 (waits on mem_ready)
// DECODE    | branch target into ALUOut, dispatch on opcode
// EXECUTE   | R-type ALU operation
// ALU_WB    | write R-type result to rd
// MEM_ADDR  | compute load/store address
// MEM_READ  | data read (waits on mem_ready)
// MEM_WB    | write load data to rt
// MEM_WRITE | data write (waits on mem_ready)
// BRANCH    | compare, conditional PC load from ALUOut
// IMM_EXEC  | immediate ALU operation
// IMM_WB    | write immediate result to rt
// JUMP      | PC load from jump target
// HALT      | bus timeout, exit only by reset
module multicycle_control #(
  parameter int unsigned INSTR_COUNT_WIDTH = 32,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_control_if.master         bus,
  output logic [INSTR_COUNT_WIDTH-1:0] instr_count,
  output logic                         illegal_instr,
  output logic                         bus_error
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECUTE, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB,
    MEM_WRITE, BRANCH, IMM_EXEC, IMM_WB, JUMP, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [INSTR_COUNT_WIDTH-1:0] COUNT_ONE = 1;
  localparam logic [31:0] WAIT_LAST = 32'(MEM_TIMEOUT) - 32'd1;

  state_t      state, next;
  logic [31:0] wait_cnt;
  logic        in_mem_state, timeout, retire, illegal_set, r_valid;
  logic [3:0]  alu_r, alu_i;

  logic [3:0] alu_control;
  logic       alu_src_a, pc_write, ir_write, mem_read, mem_write;
  logic       i_or_d, reg_write, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, pc_src;

  always_comb begin
    r_valid = 1'b1;
    alu_r   = 4'd2;
    unique case (bus.funct)
      6'h20:   alu_r = 4'd2;
      6'h22:   alu_r = 4'd6;
      6'h24:   alu_r = 4'd0;
      6'h25:   alu_r = 4'd1;
      6'h27:   alu_r = 4'd12;
      6'h2A:   alu_r = 4'd7;
      default: r_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_i = 4'd2;
    unique case (bus.opcode)
      OP_SLTI: alu_i = 4'd7;
      OP_ANDI: alu_i = 4'd0;
      OP_ORI:  alu_i = 4'd1;
      default: alu_i = 4'd2;
    endcase
  end

  assign in_mem_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  // mem_ready in the final allowed wait cycle still completes the access
  assign timeout = (MEM_TIMEOUT != 0) && in_mem_state && !bus.mem_ready &&
                   (wait_cnt == WAIT_LAST);

  always_comb begin
    next        = state;
    retire      = 1'b0;
    illegal_set = 1'b0;
    alu_control = 4'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    pc_src      = 2'd0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'd1;
        alu_control = 4'd2;
        ir_write    = bus.mem_ready;
        pc_write    = bus.mem_ready;
        if (bus.mem_ready) next = DECODE;
      end
      DECODE: begin
        alu_src_b   = 2'd3;
        alu_control = 4'd2;
        unique case (bus.opcode)
          OP_RTYPE: begin
            if (r_valid) next = EXECUTE;
            else begin
              next        = FETCH;
              illegal_set = 1'b1;
            end
          end
          OP_LW, OP_SW:                      next = MEM_ADDR;
          OP_BEQ, OP_BNE:                    next = BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next = IMM_EXEC;
          OP_J:                              next = JUMP;
          default: begin
            next        = FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = alu_r;
        next        = ALU_WB;
      end
      ALU_WB: begin
        alu_control = alu_r;
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        next        = FETCH;
        retire      = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_control = 4'd2;
        next        = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) next = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next       = FETCH;
        retire     = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          next   = FETCH;
          retire = 1'b1;
        end
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 4'd6;
        pc_src      = 2'd1;
        pc_write    = ((bus.opcode == OP_BEQ) && bus.zero) ||
                      ((bus.opcode == OP_BNE) && !bus.zero);
        next        = FETCH;
        retire      = 1'b1;
      end
      IMM_EXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_control = alu_i;
        next        = IMM_WB;
      end
      IMM_WB: begin
        alu_control = alu_i;
        reg_write   = 1'b1;
        next        = FETCH;
        retire      = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
        next     = FETCH;
        retire   = 1'b1;
      end
      HALT: next = HALT;
      default: next = FETCH;
    endcase
    if (timeout) next = HALT;
    // the state register only settles on FETCH once reset is seen, so mask strobes directly
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              wait_cnt <= 32'd0;
    else if (next != state)                 wait_cnt <= 32'd0;
    else if (in_mem_state && !bus.mem_ready) wait_cnt <= wait_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count   <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      if (retire)      instr_count   <= instr_count + COUNT_ONE;
      if (illegal_set) illegal_instr <= 1'b1;
      if (timeout)     bus_error     <= 1'b1;
    end
  end

  assign bus.alu_control = alu_control;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.pc_src      = pc_src;
  assign bus.pc_write    = pc_write;
  assign bus.ir_write    = ir_write;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.i_or_d      = i_or_d;
  assign bus.reg_write   = reg_write;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control vectors,
// which are popped and compared against the controller cycle by cycle.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_count;
  logic        illegal_instr, bus_error;

  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control #(.INSTR_COUNT_WIDTH(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .instr_count(instr_count), .illegal_instr(illegal_instr), .bus_error(bus_error)
  );

  typedef struct {
    logic        rdy;
    logic [16:0] vec;
  } step_t;

  step_t       sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cnt_model = 0;
  logic        ill_model = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // {alu_control, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, mem_read, mem_write,
  //  i_or_d, reg_write, reg_dst, mem_to_reg}
  function automatic logic [16:0] cv(input logic [3:0] alu, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic pw, input logic irw,
                                     input logic mr, input logic mw, input logic iod,
                                     input logic rw, input logic rd, input logic m2r);
    return {alu, sa, sb, ps, pw, irw, mr, mw, iod, rw, rd, m2r};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.pc_write,
            bus.ir_write, bus.mem_read, bus.mem_write, bus.i_or_d, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg};
  endfunction

  function automatic logic [4:0] r_alu(input logic [5:0] fn);  // bit4 = valid
    case (fn)
      6'h20: return 5'h12;
      6'h22: return 5'h16;
      6'h24: return 5'h10;
      6'h25: return 5'h11;
      6'h27: return 5'h1C;
      6'h2A: return 5'h17;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h0A: return 4'd7;
      6'h0C: return 4'd0;
      6'h0D: return 4'd1;
      default: return 4'd2;
    endcase
  endfunction

  task automatic push(input logic r, input logic [16:0] v);
    step_t s;
    s.rdy = r;
    s.vec = v;
    sb_q.push_back(s);
  endtask

  // Pops one expectation per cycle; inputs change 1 time unit after the rising edge.
  task automatic drain(input string tag);
    step_t s;
    int    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus.mem_ready = s.rdy;
      @(negedge clk);
      chk_val($sformatf("%s_cyc%0d", tag, i), 32'(observed()), 32'(s.vec));
      @(posedge clk);
      #1;
      i++;
    end
  endtask

  task automatic issue(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int fetch_waits, input int mem_waits);
    logic [4:0] ra;
    logic       valid;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    ra    = r_alu(fn);
    valid = 1'b1;
    repeat (fetch_waits) push(1'b0, cv(4'd2, 0, 2'd1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0));
    push(1'b1, cv(4'd2, 0, 2'd1, 2'd0, 1, 1, 1, 0, 0, 0, 0, 0));
    push(1'b1, cv(4'd2, 0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      6'h00: begin
        if (ra[4]) begin
          push(1'b1, cv(ra[3:0], 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
          push(1'b1, cv(ra[3:0], 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0));
        end else valid = 1'b0;
      end
      6'h23: begin
        push(1'b1, cv(4'd2, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (mem_waits) push(1'b0, cv(4'd0, 0, 2'd0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 0));
        push(1'b1, cv(4'd0, 0, 2'd0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 0));
        push(1'b1, cv(4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 1));
      end
      6'h2B: begin
        push(1'b1, cv(4'd2, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (mem_waits) push(1'b0, cv(4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0));
        push(1'b1, cv(4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0));
      end
      6'h04, 6'h05:
        push(1'b1, cv(4'd6, 1, 2'd0, 2'd1, (op == 6'h04) ? z : !z, 0, 0, 0, 0, 0, 0, 0));
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        push(1'b1, cv(i_alu(op), 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(1'b1, cv(i_alu(op), 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0));
      end
      6'h02: push(1'b1, cv(4'd0, 0, 2'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0));
      default: valid = 1'b0;
    endcase
    if (valid) cnt_model = cnt_model + 32'd1;
    else       ill_model = 1'b1;
    drain(tag);
    chk_val({tag, "_count"}, instr_count, cnt_model);
    chk_val({tag, "_illegal"}, 32'(illegal_instr), 32'(ill_model));
  endtask

  task automatic check_reset_state(input string tag);
    chk_val({tag, "_vec"}, 32'(observed()),
            32'(cv(4'd2, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk_val({tag, "_count"}, instr_count, 32'd0);
    chk_val({tag, "_illegal"}, 32'(illegal_instr), 32'd0);
    chk_val({tag, "_buserr"}, 32'(bus_error), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    issue("add",  6'h00, 6'h20, 1'b0, 0, 0);
    issue("lw",   6'h23, 6'h00, 1'b0, 0, 3);
    issue("beq",  6'h04, 6'h00, 1'b1, 0, 0);
    issue("bne",  6'h05, 6'h00, 1'b1, 0, 0);
    issue("bne0", 6'h05, 6'h00, 1'b0, 0, 0);
    issue("slti", 6'h0A, 6'h00, 1'b0, 0, 0);
    issue("nor",  6'h00, 6'h27, 1'b0, 0, 0);
    issue("sub",  6'h00, 6'h22, 1'b0, 3, 0);
    issue("and",  6'h00, 6'h24, 1'b0, 0, 0);
    issue("or",   6'h00, 6'h25, 1'b0, 0, 0);
    issue("slt",  6'h00, 6'h2A, 1'b0, 0, 0);
    issue("sw",   6'h2B, 6'h00, 1'b0, 1, 3);
    issue("addi", 6'h08, 6'h00, 1'b0, 0, 0);
    issue("andi", 6'h0C, 6'h00, 1'b0, 0, 0);
    issue("ori",  6'h0D, 6'h00, 1'b0, 0, 0);
    issue("j",    6'h02, 6'h00, 1'b0, 0, 0);
    issue("bad_op",    6'h3F, 6'h00, 1'b0, 0, 0);
    issue("after_bad", 6'h00, 6'h20, 1'b0, 0, 0);
    issue("bad_funct", 6'h00, 6'h00, 1'b0, 0, 0);
    issue("beq_nt",    6'h04, 6'h00, 1'b0, 0, 0);

    // fetch starved for four cycles -> HALT with every enable low, even once mem_ready returns
    repeat (4) push(1'b0, cv(4'd2, 0, 2'd1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0));
    repeat (3) push(1'b1, cv(4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    drain("timeout");
    chk_val("timeout_buserr", 32'(bus_error), 32'd1);
    chk_val("timeout_count", instr_count, cnt_model);

    reset = 1'b1;
    #2;
    check_reset_state("halt_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    cnt_model = 0;
    ill_model = 1'b0;
    issue("post_reset_add", 6'h00, 6'h20, 1'b0, 0, 0);
    issue("post_reset_lw",  6'h23, 6'h00, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
